// File: rtl/edge_detector.sv
// ============================================================================
//  Module      : edge_detector
//  Description : Multi-bit synchroniser with registered single-cycle rise and
//                fall pulses. Each bit of async_sig passes through its own
//                SYNC_STAGES-deep flop chain. A history flop then compares
//                the synchronised level with its value one cycle earlier.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_detector #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,      // synchronous, active-low
    input  logic [WIDTH-1:0] async_sig,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] level
);

    // Keep the chain depth inside the supported 2..4 range so that a stray
    // parameter value cannot collapse the synchroniser into a single flop.
    localparam int c_STAGES = (SYNC_STAGES < 2) ? 2 :
                              (SYNC_STAGES > 4) ? 4 : SYNC_STAGES;
    localparam int c_LAST   = c_STAGES - 1;

    // Stage 0 is the metastability-exposed capture flop. Stage c_LAST is the
    // first stage that is treated as a stable level.
    logic [c_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]               hist_q;
    logic [WIDTH-1:0]               rise_q;
    logic [WIDTH-1:0]               fall_q;
    logic [WIDTH-1:0]               rise_d;
    logic [WIDTH-1:0]               fall_d;

    // Edge classification from the stable stage and the previous level.
    // Because history is cleared by reset, an input that is already high at
    // release looks like a genuine 0->1 edge and produces one rise pulse.
    always_comb begin
        rise_d = sync_q[c_LAST] & ~hist_q;
        fall_d = ~sync_q[c_LAST] & hist_q;
    end

    // Synchroniser chain, history and output pulse registers. Reset clears
    // everything, including a pulse that would otherwise be set on this edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= '0;
            hist_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            sync_q[0] <= async_sig;
            for (int i = 1; i < c_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            hist_q <= sync_q[c_LAST];
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    // Every output is driven straight from a flop. There is no combinational
    // path from async_sig.
    assign rise  = rise_q;
    assign fall  = fall_q;
    assign level = sync_q[c_LAST];

endmodule

`default_nettype wire

// File: tb/tb_edge_detector.sv
// ============================================================================
//  Module      : tb_edge_detector
//  Description : Directed self-checking bench for edge_detector
//                (WIDTH=1, SYNC_STAGES=2).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_edge_detector;

    logic clk;
    logic reset;
    logic async_sig;
    logic rise;
    logic fall;
    logic level;

    int tests_run;
    int tests_failed;
    int n_rise;
    int n_fall;

    edge_detector #(
        .WIDTH       (1),
        .SYNC_STAGES (2)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .async_sig (async_sig),
        .rise      (rise),
        .fall      (fall),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle #1 past it. Inputs set before a
    // tick are captured on that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic er, input logic ef, input logic el);
        chk({tag, ".rise"},  rise,  er);
        chk({tag, ".fall"},  fall,  ef);
        chk({tag, ".level"}, level, el);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        async_sig    = 1'b0;
        #2;

        // Reset held for 3 edges with the input low.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk3("reset_hold", 1'b0, 1'b0, 1'b0);
        end
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk3("post_reset_idle", 1'b0, 1'b0, 1'b0);
        end

        // Rising edge: captured at edge k.
        async_sig = 1'b1;
        tick();                                     // edge k
        chk3("rise_k",  1'b0, 1'b0, 1'b0);
        tick();                                     // edge k+1
        chk3("rise_k1", 1'b0, 1'b0, 1'b1);
        tick();                                     // edge k+2
        chk3("rise_k2", 1'b1, 1'b0, 1'b1);
        tick();                                     // edge k+3
        chk3("rise_k3", 1'b0, 1'b0, 1'b1);
        // The input stays high, so the pulse must not repeat.
        for (int i = 0; i < 7; i++) begin
            tick();
            chk3("rise_hold", 1'b0, 1'b0, 1'b1);
        end

        // Falling edge after the input has been high for more than 10 cycles.
        async_sig = 1'b0;
        tick();                                     // edge k
        chk3("fall_k",  1'b0, 1'b0, 1'b1);
        tick();                                     // edge k+1
        chk3("fall_k1", 1'b0, 1'b0, 1'b0);
        tick();                                     // edge k+2
        chk3("fall_k2", 1'b0, 1'b1, 1'b0);
        tick();                                     // edge k+3
        chk3("fall_k3", 1'b0, 1'b0, 1'b0);
        tick();
        chk3("fall_hold", 1'b0, 1'b0, 1'b0);

        // Reset with the input high: one rise pulse 3 edges after release.
        async_sig = 1'b1;
        reset     = 1'b0;
        tick();
        chk3("rst_hi_hold0", 1'b0, 1'b0, 1'b0);
        tick();
        chk3("rst_hi_hold1", 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();                                     // release edge 1
        chk3("rst_hi_r1", 1'b0, 1'b0, 1'b0);
        tick();                                     // release edge 2
        chk3("rst_hi_r2", 1'b0, 1'b0, 1'b1);
        tick();                                     // release edge 3
        chk3("rst_hi_r3", 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk3("rst_hi_after", 1'b0, 1'b0, 1'b1);
        end

        // Fast toggle: the input goes 0,1,0,1,0,1 on edges 1..6 and then
        // holds 1. The pulse at edge e compares the input at e-2 with the
        // input at e-3. That gives fall at 3,5,7 and rise at 4,6,8.
        n_rise = 0;
        n_fall = 0;
        for (int e = 1; e <= 12; e++) begin
            async_sig = (e <= 6) ? ((e % 2) == 0) : 1'b1;
            tick();
            chk("toggle.rise", rise, (e == 4) || (e == 6) || (e == 8));
            chk("toggle.fall", fall, (e == 3) || (e == 5) || (e == 7));
            chk("toggle.not_both", rise & fall, 1'b0);
            if (rise) n_rise++;
            if (fall) n_fall++;
        end
        chk("toggle.rise_count_is3", n_rise == 3, 1'b1);
        chk("toggle.fall_count_is3", n_fall == 3, 1'b1);

        // Reset mid-pulse: reset lands on the edge that would set rise.
        async_sig = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk3("midpulse_pre", 1'b0, 1'b0, 1'b0);
        async_sig = 1'b1;
        tick();                                     // edge k
        tick();                                     // edge k+1
        chk3("midpulse_k1", 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        tick();                                     // edge k+2 under reset
        chk3("midpulse_k2", 1'b0, 1'b0, 1'b0);
        tick();
        chk3("midpulse_k3", 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        tick();
        tick();
        chk3("midpulse_recover", 1'b1, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Watchdog that guarantees the bench ends on its own.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
